// File: rtl/fir_y_byte_reader.sv
// rtl/fir_y_byte_reader.sv - captures FIR y words on the lz rising edge and streams them out as bytes
// Optional checksum byte per frame when FIR_Y_BYTE_READER_CKSUM_EN is defined.
module fir_y_byte_reader #(
  parameter int DATA_W    = 32,
  parameter int LSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] y_dat,
  input  logic              y_lz,
  output logic [7:0]        byte_out,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              byte_last,
  output logic              overrun,
  input  logic              ovr_clr,
  output logic [7:0]        words_sent
);

  localparam int NB = DATA_W / 8;
`ifdef FIR_Y_BYTE_READER_CKSUM_EN
  localparam int FL = NB + 1;
`else
  localparam int FL = NB;
`endif
  localparam int IDX_W = (FL > 1) ? $clog2(FL) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FL - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state, state_nxt;
  logic              lz_q;
  logic [DATA_W-1:0] active, pending;
  logic              pend_full;
  logic [IDX_W-1:0]  idx;
  logic              cap, accept, last_acc, drop;
  logic [7:0]        data_byte, sel_byte;

  assign cap      = y_lz & ~lz_q;
  assign accept   = (state == SEND) & byte_ready;
  assign last_acc = accept & (idx == LAST_IDX);
  // A third word arriving while both slots are occupied and nothing retires this cycle.
  assign drop     = cap & (state == SEND) & ~last_acc & pend_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (cap) state_nxt = SEND;
      SEND: if (last_acc && !pend_full && !cap) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    data_byte = '0;
    for (int i = 0; i < NB; i++) begin
      if (idx == IDX_W'(i)) begin
        data_byte = (LSB_FIRST != 0) ? active[i*8 +: 8] : active[DATA_W-8-i*8 +: 8];
      end
    end
  end

`ifdef FIR_Y_BYTE_READER_CKSUM_EN
  logic [7:0] cksum;
  always_comb begin
    cksum = '0;
    for (int i = 0; i < NB; i++) begin
      cksum = cksum ^ active[i*8 +: 8];
    end
    sel_byte = (idx == IDX_W'(NB)) ? cksum : data_byte;
  end
`else
  always_comb begin
    sel_byte = data_byte;
  end
`endif

  always_comb begin
    byte_valid = 1'b0;
    byte_last  = 1'b0;
    byte_out   = '0;
    if (state == SEND) begin
      byte_valid = 1'b1;
      byte_last  = (idx == LAST_IDX);
      byte_out   = sel_byte;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lz_q       <= 1'b1;
      active     <= '0;
      pending    <= '0;
      pend_full  <= 1'b0;
      idx        <= '0;
      words_sent <= '0;
    end else begin
      lz_q <= y_lz;
      if (state == IDLE) begin
        if (cap) begin
          active <= y_dat;
          idx    <= '0;
        end
      end else if (last_acc) begin
        words_sent <= words_sent + 8'd1;
        idx        <= '0;
        // Pending word goes next with no bubble; a same-cycle capture refills the pending slot.
        if (pend_full) begin
          active <= pending;
          if (cap) begin
            pending <= y_dat;
          end else begin
            pend_full <= 1'b0;
          end
        end else if (cap) begin
          active <= y_dat;
        end
      end else begin
        if (accept) begin
          idx <= idx + IDX_W'(1);
        end
        if (cap && !pend_full) begin
          pending   <= y_dat;
          pend_full <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (ovr_clr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_y_byte_reader.sv
// tb/tb_fir_y_byte_reader.sv - self-checking bench for fir_y_byte_reader
// Honours FIR_Y_BYTE_READER_CKSUM_EN to match the checksum build.
module tb_fir_y_byte_reader;

  localparam int NB = 4;
`ifdef FIR_Y_BYTE_READER_CKSUM_EN
  localparam int FL = NB + 1;
`else
  localparam int FL = NB;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] y_dat = '0;
  logic        y_lz = 1'b1;
  logic        byte_ready = 1'b0;
  logic        ovr_clr = 1'b0;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_last;
  logic        overrun;
  logic [7:0]  words_sent;

  fir_y_byte_reader #(.DATA_W(32), .LSB_FIRST(1)) dut (
    .clk(clk), .rst(rst), .y_dat(y_dat), .y_lz(y_lz),
    .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .byte_last(byte_last), .overrun(overrun), .ovr_clr(ovr_clr),
    .words_sent(words_sent)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: queue of held words, byte position within the head word.
  logic [31:0] mq[$];
  int          bidx = 0;
  int          m_sent = 0;
  bit          m_ovr = 0;
  bit          m_lzq = 1;

  logic [7:0] got[$];
  bit         got_last[$];
  bit         s_valid = 0;
  bit         s_last = 0;
  logic [7:0] s_byte = '0;

  typedef struct {
    logic [31:0] word;
    logic [31:0] ready_mask;
    logic [39:0] exp_bytes;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [7:0] model_byte(input logic [31:0] w, input int k);
    logic [7:0] x;
    x = '0;
    if (k == NB) begin
      for (int i = 0; i < NB; i++) x = x ^ 8'((w >> (8 * i)) & 32'hFF);
    end else begin
      x = 8'((w >> (8 * k)) & 32'hFF);
    end
    return x;
  endfunction

  task automatic compare();
    bit ev;
    ev = (mq.size() > 0);
    check("byte_valid", 32'(byte_valid), 32'(ev));
    check("byte_last", 32'(byte_last), 32'(ev && bidx == FL - 1));
    if (ev) check("byte_out", 32'(byte_out), 32'(model_byte(mq[0], bidx)));
    check("overrun", 32'(overrun), 32'(m_ovr));
    check("words_sent", 32'(words_sent), 32'(m_sent));
    s_valid = byte_valid;
    s_last  = byte_last;
    s_byte  = byte_out;
  endtask

  task automatic step();
    bit cap, acc, dropped;
    @(posedge clk);
    if (s_valid && byte_ready) begin
      got.push_back(s_byte);
      got_last.push_back(s_last);
    end
    if (!rst) begin
      cap = y_lz && !m_lzq;
      m_lzq = y_lz;
      acc = (mq.size() > 0) && byte_ready;
      dropped = 0;
      if (acc) begin
        if (bidx == FL - 1) begin
          void'(mq.pop_front());
          bidx = 0;
          m_sent = (m_sent + 1) % 256;
        end else begin
          bidx++;
        end
      end
      if (cap) begin
        if (mq.size() < 2) mq.push_back(y_dat);
        else dropped = 1;
      end
      if (dropped) m_ovr = 1;
      else if (ovr_clr) m_ovr = 0;
    end
    #1;
    compare();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    mq.delete();
    bidx = 0;
    m_sent = 0;
    m_ovr = 0;
    m_lzq = 1;
    check("rst_byte_out", 32'(byte_out), 32'h0);
    compare();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse(input logic [31:0] w);
    y_dat = w;
    y_lz = 1'b1;
    step();
    y_lz = 1'b0;
    step();
  endtask

  initial begin
    int run, max_run, base;
    logic [31:0] m;

    vecs[0] = '{32'h11223344, 32'hFFFFFFFF, 40'h44_11223344};
    vecs[1] = '{32'h11223344, 32'h99999999, 40'h44_11223344};
    vecs[2] = '{32'hDEADBEEF, 32'hFFFFFFFF, 40'h22_DEADBEEF};
    vecs[3] = '{32'h000000FF, 32'h55555555, 40'hFF_000000FF};

    // y_lz held high through reset must not capture.
    #1;
    compare();
    @(negedge clk);
    rst = 1'b0;
    step();
    step();
    y_lz = 1'b0;
    step();
    check("no_capture_after_reset", 32'(byte_valid), 32'h0);

    for (int v = 0; v < 4; v++) begin
      got.delete();
      got_last.delete();
      base = m_sent;
      y_dat = vecs[v].word;
      y_lz = 1'b1;
      step();
      y_lz = 1'b0;
      m = vecs[v].ready_mask;
      for (int c = 0; c < 20; c++) begin
        byte_ready = m[c];
        step();
      end
      byte_ready = 1'b0;
      check($sformatf("vec%0d_nbytes", v), 32'(got.size()), 32'(FL));
      for (int k = 0; k < FL && k < got.size(); k++) begin
        m = 32'(vecs[v].exp_bytes >> (8 * k));
        check($sformatf("vec%0d_byte%0d", v, k), 32'(got[k]), m & 32'hFF);
        check($sformatf("vec%0d_last%0d", v, k), 32'(got_last[k]), 32'(k == FL - 1));
      end
      check($sformatf("vec%0d_sent", v), 32'(words_sent), 32'((base + 1) % 256));
      step();
      check($sformatf("vec%0d_idle", v), 32'(byte_valid), 32'h0);
    end

    // Pending word follows with no bubble.
    got.delete();
    got_last.delete();
    base = m_sent;
    byte_ready = 1'b1;
    y_dat = 32'hA0A1A2A3;
    y_lz = 1'b1;
    step();
    y_lz = 1'b0;
    run = 0;
    max_run = 0;
    for (int c = 0; c < 14; c++) begin
      if (c == 1) begin y_dat = 32'hB0B1B2B3; y_lz = 1'b1; end
      else y_lz = 1'b0;
      if (byte_valid) run++; else run = 0;
      if (run > max_run) max_run = run;
      step();
    end
    check("zb_run", 32'(max_run), 32'(2 * FL));
    check("zb_nbytes", 32'(got.size()), 32'(2 * FL));
    if (got.size() > FL) begin
      check("zb_first_a", 32'(got[0]), 32'hA3);
      check("zb_first_b", 32'(got[FL]), 32'hB3);
    end
    check("zb_sent", 32'(words_sent), 32'((base + 2) % 256));
    check("zb_ovr", 32'(overrun), 32'h0);

    // Overrun: three words with ready low, only the first two survive.
    got.delete();
    byte_ready = 1'b0;
    pulse(32'h01010101);
    pulse(32'h02020202);
    pulse(32'h03030303);
    check("ovr_set", 32'(overrun), 32'h1);
    byte_ready = 1'b1;
    for (int c = 0; c < 16; c++) step();
    check("ovr_nbytes", 32'(got.size()), 32'(2 * FL));
    if (got.size() > FL) begin
      check("ovr_w1", 32'(got[0]), 32'h01);
      check("ovr_w2", 32'(got[FL]), 32'h02);
    end
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    check("ovr_clear", 32'(overrun), 32'h0);
    byte_ready = 1'b0;
    pulse(32'h04040404);
    pulse(32'h05050505);
    y_dat = 32'h06060606;
    y_lz = 1'b1;
    ovr_clr = 1'b1;
    step();
    y_lz = 1'b0;
    ovr_clr = 1'b0;
    check("ovr_set_beats_clr", 32'(overrun), 32'h1);
    byte_ready = 1'b1;
    for (int c = 0; c < 16; c++) step();

    // Level strobe gives one frame.
    got.delete();
    base = m_sent;
    y_dat = 32'hCAFEF00D;
    y_lz = 1'b1;
    for (int c = 0; c < 5; c++) step();
    y_lz = 1'b0;
    for (int c = 0; c < 10; c++) step();
    check("level_nbytes", 32'(got.size()), 32'(FL));
    check("level_sent", 32'(words_sent), 32'((base + 1) % 256));

    // Reset after two bytes of a frame.
    y_dat = 32'h55667788;
    y_lz = 1'b1;
    step();
    y_lz = 1'b0;
    step();
    step();
    do_reset();
    check("rst_valid", 32'(byte_valid), 32'h0);
    check("rst_sent", 32'(words_sent), 32'h0);
    step();

    // 256 frames wrap words_sent.
    byte_ready = 1'b1;
    for (int f = 0; f < 256; f++) begin
      y_dat = $urandom;
      y_lz = 1'b1;
      step();
      y_lz = 1'b0;
      for (int c = 0; c < FL; c++) step();
      if (f == 254) check("wrap_255", 32'(words_sent), 32'd255);
    end
    check("wrap_0", 32'(words_sent), 32'd0);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      y_dat = $urandom;
      y_lz = ($urandom_range(0, 3) == 0);
      byte_ready = $urandom_range(0, 1);
      ovr_clr = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
